// File: rtl/counter_chain_sequencer.sv
// counter_chain_sequencer
//   Runs a cascade of 74161A-style 4-bit counters as a programmable-period
//   divider and emits one tick per period. The preload is double-buffered:
//   host writes made while busy take effect at the next terminal count.
// Ports
//   Clk, Reset        clock and asynchronous active-high reset
//   start/stop/hold   control: start and stop are pulses, hold is a level
//   cfg_we/preload    preload write strobe and value
//   cnt_q, cnt_rco    chain Q readback (debug only) and last-stage RCO
//   cnt_clear_bar,    chain controls: clear, load, first-stage ENT,
//   cnt_load_bar,     shared ENP and preload data
//   cnt_ent, cnt_enp,
//   cnt_d
//   tick, busy        terminal-count pulse and active indicator
//   cfg_pending       shadow preload written but not yet applied
module counter_chain_sequencer #(
  parameter int unsigned       WIDTH           = 8,
  parameter logic [WIDTH-1:0]  DEFAULT_PRELOAD = '0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] cfg_preload,
  input  logic [WIDTH-1:0] cnt_q,
  input  logic             cnt_rco,
  output logic             cnt_clear_bar,
  output logic             cnt_load_bar,
  output logic             cnt_ent,
  output logic             cnt_enp,
  output logic [WIDTH-1:0] cnt_d,
  output logic             tick,
  output logic             busy,
  output logic             cfg_pending
);

  // The chain is built from 4-bit stages.
  if ((WIDTH % 4) != 0) begin : g_width_check
    $error("counter_chain_sequencer: WIDTH must be a multiple of 4");
  end

  typedef enum logic [1:0] {IDLE, PRIME, RUN, HOLD} state_t;

  state_t           state;
  logic [WIDTH-1:0] active;
  logic [WIDTH-1:0] shadow;
  logic             pending;
  logic             term_cnt;
  logic [WIDTH-1:0] reload;

  // Chain readback is status only; nothing in the control path depends on it.
  logic unused_cnt_q;
  assign unused_cnt_q = ^cnt_q;

  // Terminal count only matters while the chain is actually counting.
  assign term_cnt = (state == RUN) && cnt_rco;
  assign reload   = pending ? shadow : active;

  // State and preload bookkeeping.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      active  <= DEFAULT_PRELOAD;
      shadow  <= DEFAULT_PRELOAD;
      pending <= 1'b0;
    end else begin
      case (state)
        IDLE:    if (start && !stop && !hold) state <= PRIME;
        PRIME:   state <= stop ? IDLE : RUN;
        RUN:     if (stop) state <= IDLE;
                 else if (hold) state <= HOLD;
        HOLD:    if (stop) state <= IDLE;
                 else if (!hold) state <= RUN;
        default: state <= IDLE;
      endcase

      // The chain reloads on the terminal-count edge; mirror what it loads.
      if (term_cnt) begin
        active  <= reload;
        pending <= 1'b0;
      end

      // Later assignment wins: a write on the terminal-count edge stays pending.
      if (cfg_we) begin
        shadow <= cfg_preload;
        if (state == IDLE) begin
          active  <= cfg_preload;
          pending <= 1'b0;
        end else begin
          pending <= 1'b1;
        end
      end
    end
  end

  // Chain control decode; load and tick follow RCO within the cycle.
  always_comb begin
    cnt_clear_bar = 1'b1;
    cnt_load_bar  = 1'b1;
    cnt_ent       = 1'b0;
    cnt_enp       = 1'b0;
    cnt_d         = active;
    tick          = 1'b0;
    case (state)
      IDLE:  cnt_clear_bar = 1'b0;
      PRIME: cnt_load_bar  = 1'b0;
      RUN: begin
        cnt_ent      = 1'b1;
        cnt_enp      = 1'b1;
        cnt_load_bar = !cnt_rco;
        tick         = cnt_rco;
        if (cnt_rco) cnt_d = reload;
      end
      // ENT stays high so RCO remains visible; ENP low freezes the count.
      HOLD:  cnt_ent = 1'b1;
      default: cnt_clear_bar = 1'b0;
    endcase
  end

  assign busy        = (state != IDLE);
  assign cfg_pending = pending;

endmodule
